sync_fifo_fwft: RTL and testbench

Single-clock, parametrised FIFO: the same-clock counterpart of our asynchronous FIFO, for buffering inside one clock domain. Adds selectable first-word-fall-through (FWFT) or standard read mode, an exported fill level, synchronous flush, and sticky overflow/underflow error flags with explicit clear. Used between pipeline stages and stream endpoints, such as video line buffers and UART/SPI data paths.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/fifo_sdp_ram.sv | 33 +++
 rtl/sync_fifo_fwft.sv | 155 +++++++++++++++
 tb/tb_sync_fifo_fwft.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and parameter helpers for the single-clock FIFO family
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Binary pointers carry one extra bit so full and empty are distinguishable.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  function automatic bit depth_ok(input int depth);
    return is_pow2(depth) && (depth >= 4);
  endfunction

  function automatic bit thresholds_ok(input int depth, input int af_thr, input int ae_thr);
    return (af_thr >= 0) && (ae_thr >= 0) && (af_thr < depth) && (ae_thr < depth);
  endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// rtl/fifo_sdp_ram.sv - simple dual-port RAM, one write port and one registered read port
module fifo_sdp_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  (* ramstyle = "no_rw_check" *) logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The read register doubles as the FIFO output register, so it is reset and holds when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - single-clock FIFO with standard or first-word-fall-through read mode
module sync_fifo_fwft
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH             = 16,
  parameter int DEPTH                  = 1024,
  parameter int ALMOST_FULL_THRESHOLD  = 16,
  parameter int ALMOST_EMPTY_THRESHOLD = 16,
  parameter int FWFT                   = 0,
  parameter int ADDR_WIDTH             = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  full_o,
  output logic                  almost_full_o,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  empty_o,
  output logic                  almost_empty_o,
  output logic [ADDR_WIDTH:0]   fill_count_o,
  output logic                  overflow_o,
  output logic                  underflow_o,
  input  logic                  clear_err_i
);

  localparam int         PTR_W = ptr_width(DEPTH);
  localparam int         CNT_W = ADDR_WIDTH + 1;
  localparam fifo_mode_e MODE  = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(DEPTH - ALMOST_FULL_THRESHOLD);
  localparam logic [CNT_W-1:0] AE_LVL   = CNT_W'(ALMOST_EMPTY_THRESHOLD);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_fwft: DEPTH must be a power of two and at least 4");
  end
  if (!thresholds_ok(DEPTH, ALMOST_FULL_THRESHOLD, ALMOST_EMPTY_THRESHOLD)) begin : g_bad_thr
    $error("sync_fifo_fwft: almost-full/almost-empty thresholds must be below DEPTH");
  end
  if (PTR_W != CNT_W) begin : g_bad_addr
    $error("sync_fifo_fwft: ADDR_WIDTH is derived from DEPTH and must not be overridden");
  end

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fill_next;
  logic             wr_acc;
  logic             rd_acc;
  logic             mem_has_data;
  logic             refill;
  logic             ram_re;
  logic             out_valid;
  logic             out_valid_next;
  logic             empty_next;

  assign wr_acc       = wr_en_i && !full_o && !flush_i;
  assign rd_acc       = rd_en_i && !empty_o && !flush_i;
  assign mem_has_data = (wr_ptr != rd_ptr);
  assign rd_valid_o   = out_valid;

  always_comb begin
    fill_next = fill_count_o;
    if (flush_i) begin
      fill_next = '0;
    end else if (wr_acc && !rd_acc) begin
      fill_next = fill_count_o + CNT_W'(1);
    end else if (rd_acc && !wr_acc) begin
      fill_next = fill_count_o - CNT_W'(1);
    end
  end

  // In FWFT mode the RAM read register is the head-of-queue holder; it is reloaded
  // whenever it is vacant or being popped, so fill counts it but empty tracks it alone.
  always_comb begin
    refill         = !flush_i && mem_has_data && (!out_valid || rd_acc);
    ram_re         = rd_acc;
    out_valid_next = rd_acc;
    empty_next     = (fill_next == '0);
    if (MODE == FIFO_FWFT) begin
      ram_re = refill;
      if (flush_i) begin
        out_valid_next = 1'b0;
      end else if (refill) begin
        out_valid_next = 1'b1;
      end else if (rd_acc) begin
        out_valid_next = 1'b0;
      end else begin
        out_valid_next = out_valid;
      end
      empty_next = !out_valid_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fill_count_o   <= '0;
      full_o         <= 1'b0;
      almost_full_o  <= 1'b0;
      empty_o        <= 1'b1;
      almost_empty_o <= 1'b1;
      out_valid      <= 1'b0;
      overflow_o     <= 1'b0;
      underflow_o    <= 1'b0;
    end else begin
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (ram_re) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
      end
      fill_count_o   <= fill_next;
      full_o         <= (fill_next == FULL_LVL);
      almost_full_o  <= (fill_next >= AF_LVL);
      empty_o        <= empty_next;
      almost_empty_o <= (fill_next <= AE_LVL);
      out_valid      <= out_valid_next;
      if (wr_en_i && full_o) begin
        overflow_o <= 1'b1;
      end else if (clear_err_i) begin
        overflow_o <= 1'b0;
      end
      if (rd_en_i && empty_o) begin
        underflow_o <= 1'b1;
      end else if (clear_err_i) begin
        underflow_o <= 1'b0;
      end
    end
  end

  fifo_sdp_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk    (clk_i),
    .rst    (rst_i),
    .wr_en  (wr_acc),
    .wr_addr(wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data(wr_data_i),
    .rd_en  (ram_re),
    .rd_addr(rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data(rd_data_o)
  );

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// tb/tb_sync_fifo_fwft.sv - self-checking bench for sync_fifo_fwft in both read modes
module tb_sync_fifo_fwft;

  localparam int DEPTH = 8;

  typedef struct {
    bit         wr;
    logic [7:0] wd;
    bit         rd;
    bit         clr;
    logic [3:0] fill;
    bit         full;
    bit         af;
    bit         empty;
    bit         ae;
    bit         rv;
    logic [7:0] data;
    bit         ovf;
    bit         udf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] wr_data = 8'h00;

  logic       full [2];
  logic       afull [2];
  logic       rvalid [2];
  logic       empty [2];
  logic       aempty [2];
  logic       ovf [2];
  logic       udf [2];
  logic [7:0] rdata [2];
  logic [3:0] fill [2];

  int tests = 0;
  int fails = 0;

  // Reference model: one word queue per mode; in FWFT a word is visible once it
  // sat in the FIFO across an edge while at the head.
  logic [7:0] qs[$];
  logic [7:0] qf[$];
  bit         shown, rv_s, ovf_s, udf_s, ovf_f, udf_f;
  logic [7:0] dat_s;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 2; m++) begin : g_dut
    sync_fifo_fwft #(
      .DATA_WIDTH(8),
      .DEPTH(DEPTH),
      .ALMOST_FULL_THRESHOLD(2),
      .ALMOST_EMPTY_THRESHOLD(2),
      .FWFT(m)
    ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .flush_i       (flush),
      .wr_en_i       (wr_en),
      .wr_data_i     (wr_data),
      .full_o        (full[m]),
      .almost_full_o (afull[m]),
      .rd_en_i       (rd_en),
      .rd_data_o     (rdata[m]),
      .rd_valid_o    (rvalid[m]),
      .empty_o       (empty[m]),
      .almost_empty_o(aempty[m]),
      .fill_count_o  (fill[m]),
      .overflow_o    (ovf[m]),
      .underflow_o   (udf[m]),
      .clear_err_i   (clr)
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input bit wr, input logic [7:0] wd, input bit rd, input bit c,
                              input logic [3:0] f, input bit fu, input bit af, input bit em,
                              input bit ae, input bit rv, input logic [7:0] d, input bit o,
                              input bit u);
    vec_t v;
    v.wr = wr; v.wd = wd; v.rd = rd; v.clr = c; v.fill = f; v.full = fu; v.af = af;
    v.empty = em; v.ae = ae; v.rv = rv; v.data = d; v.ovf = o; v.udf = u;
    return v;
  endfunction

  task automatic model_reset();
    qs.delete();
    qf.delete();
    shown = 0; rv_s = 0; ovf_s = 0; udf_s = 0; ovf_f = 0; udf_f = 0;
    dat_s = 8'h00;
  endtask

  task automatic model_step();
    int  ns, nf;
    bit  pop;
    ns = qs.size();
    nf = qf.size();
    if (wr_en && ns == DEPTH) ovf_s = 1; else if (clr) ovf_s = 0;
    if (rd_en && ns == 0) udf_s = 1; else if (clr) udf_s = 0;
    if (wr_en && nf == DEPTH) ovf_f = 1; else if (clr) ovf_f = 0;
    if (rd_en && !shown) udf_f = 1; else if (clr) udf_f = 0;
    rv_s = 0;
    if (flush) begin
      qs.delete();
      qf.delete();
      shown = 0;
    end else begin
      if (rd_en && ns > 0) begin
        dat_s = qs.pop_front();
        rv_s  = 1;
      end
      if (wr_en && ns < DEPTH) qs.push_back(wr_data);
      pop = rd_en && shown;
      if (pop) void'(qf.pop_front());
      if (!(shown && !pop)) shown = (nf - int'(pop)) > 0;
      if (wr_en && nf < DEPTH) qf.push_back(wr_data);
    end
  endtask

  task automatic check_all();
    int ns, nf;
    ns = qs.size();
    nf = qf.size();
    chk("s_fill",   32'(fill[0]),   32'(ns));
    chk("s_full",   32'(full[0]),   32'(ns == DEPTH));
    chk("s_afull",  32'(afull[0]),  32'(ns >= DEPTH - 2));
    chk("s_empty",  32'(empty[0]),  32'(ns == 0));
    chk("s_aempty", 32'(aempty[0]), 32'(ns <= 2));
    chk("s_valid",  32'(rvalid[0]), 32'(rv_s));
    chk("s_data",   32'(rdata[0]),  32'(dat_s));
    chk("s_ovf",    32'(ovf[0]),    32'(ovf_s));
    chk("s_udf",    32'(udf[0]),    32'(udf_s));
    chk("f_fill",   32'(fill[1]),   32'(nf));
    chk("f_full",   32'(full[1]),   32'(nf == DEPTH));
    chk("f_afull",  32'(afull[1]),  32'(nf >= DEPTH - 2));
    chk("f_empty",  32'(empty[1]),  32'(!shown));
    chk("f_aempty", 32'(aempty[1]), 32'(nf <= 2));
    chk("f_valid",  32'(rvalid[1]), 32'(shown));
    if (shown) chk("f_data", 32'(rdata[1]), 32'(qf[0]));
    chk("f_ovf",    32'(ovf[1]),    32'(ovf_f));
    chk("f_udf",    32'(udf[1]),    32'(udf_f));
  endtask

  task automatic drive(input bit w, input logic [7:0] d, input bit r, input bit f, input bit c);
    wr_en = w; wr_data = d; rd_en = r; flush = f; clr = c;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    vec_t vecs[19];
    for (int k = 1; k <= 8; k++)
      vecs[k-1] = mk(1, 8'(k), 0, 0, 4'(k), k == 8, k >= 6, 0, k <= 2, 0, 8'h00, 0, 0);
    vecs[8] = mk(1, 8'h09, 0, 0, 4'd8, 1, 1, 0, 0, 0, 8'h00, 1, 0);
    for (int j = 1; j <= 8; j++)
      vecs[8+j] = mk(0, 8'h00, 1, 0, 4'(8 - j), 0, (8 - j) >= 6, j == 8, (8 - j) <= 2, 1, 8'(j), 1, 0);
    vecs[17] = mk(0, 8'h00, 1, 0, 4'd0, 0, 0, 1, 1, 0, 8'h08, 1, 1);
    vecs[18] = mk(0, 8'h00, 0, 1, 4'd0, 0, 0, 1, 1, 0, 8'h08, 0, 0);

    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all();

    // Fill to full, overflow, drain in order, underflow, clear (standard instance table)
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].wr, vecs[i].wd, vecs[i].rd, 1'b0, vecs[i].clr);
      tick();
      chk($sformatf("tbl%0d_fill", i),   32'(fill[0]),   32'(vecs[i].fill));
      chk($sformatf("tbl%0d_full", i),   32'(full[0]),   32'(vecs[i].full));
      chk($sformatf("tbl%0d_afull", i),  32'(afull[0]),  32'(vecs[i].af));
      chk($sformatf("tbl%0d_empty", i),  32'(empty[0]),  32'(vecs[i].empty));
      chk($sformatf("tbl%0d_aempty", i), 32'(aempty[0]), 32'(vecs[i].ae));
      chk($sformatf("tbl%0d_valid", i),  32'(rvalid[0]), 32'(vecs[i].rv));
      chk($sformatf("tbl%0d_data", i),   32'(rdata[0]),  32'(vecs[i].data));
      chk($sformatf("tbl%0d_ovf", i),    32'(ovf[0]),    32'(vecs[i].ovf));
      chk($sformatf("tbl%0d_udf", i),    32'(udf[0]),    32'(vecs[i].udf));
    end

    // FWFT latency: visible one edge after the write edge, gone after the pop
    drive(1, 8'hA5, 0, 0, 0); tick();
    chk("fwft_empty_after_n", 32'(empty[1]), 32'd1);
    drive(0, 8'h00, 0, 0, 0); tick();
    chk("fwft_empty_after_n1", 32'(empty[1]), 32'd0);
    chk("fwft_data_after_n1", 32'(rdata[1]), 32'hA5);
    drive(0, 8'h00, 1, 0, 0); tick();
    chk("fwft_empty_after_pop", 32'(empty[1]), 32'd1);

    // Full-rate wrap-around from fill 3
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'(16 + i), 0, 0, 0); tick();
    end
    for (int i = 0; i < 40; i++) begin
      drive(1, 8'(19 + i), 1, 0, 0); tick();
      chk("wrap_s_fill", 32'(fill[0]), 32'd3);
      chk("wrap_f_fill", 32'(fill[1]), 32'd3);
      chk("wrap_s_data", 32'(rdata[0]), 32'(8'(16 + i)));
      chk("wrap_f_data", 32'(rdata[1]), 32'(8'(17 + i)));
    end

    // Flush versus traffic, sticky flags untouched by flush, set beats clear
    drive(0, 8'h00, 0, 1, 0); tick();
    drive(0, 8'h00, 1, 0, 0); tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'(32 + i), 0, 0, 0); tick();
    end
    drive(1, 8'hEE, 1, 1, 0); tick();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("flush%0d_fill", m),  32'(fill[m]),  32'd0);
      chk($sformatf("flush%0d_empty", m), 32'(empty[m]), 32'd1);
      chk($sformatf("flush%0d_udf", m),   32'(udf[m]),   32'd1);
      chk($sformatf("flush%0d_ovf", m),   32'(ovf[m]),   32'd0);
    end
    drive(0, 8'h00, 0, 0, 0); tick();
    chk("flush_nowrite_s", 32'(fill[0]), 32'd0);
    chk("flush_nowrite_f", 32'(empty[1]), 32'd1);
    drive(0, 8'h00, 1, 0, 1); tick();
    chk("setwins_s", 32'(udf[0]), 32'd1);
    chk("setwins_f", 32'(udf[1]), 32'd1);
    drive(0, 8'h00, 0, 0, 1); tick();

    // Async reset between edges at fill 6
    drive(0, 8'h00, 1, 0, 0); tick();
    for (int i = 0; i < 6; i++) begin
      drive(1, 8'(64 + i), 0, 0, 0); tick();
    end
    drive(0, 8'h00, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("rst%0d_fill", m),   32'(fill[m]),   32'd0);
      chk($sformatf("rst%0d_full", m),   32'(full[m]),   32'd0);
      chk($sformatf("rst%0d_afull", m),  32'(afull[m]),  32'd0);
      chk($sformatf("rst%0d_empty", m),  32'(empty[m]),  32'd1);
      chk($sformatf("rst%0d_aempty", m), 32'(aempty[m]), 32'd1);
      chk($sformatf("rst%0d_valid", m),  32'(rvalid[m]), 32'd0);
      chk($sformatf("rst%0d_data", m),   32'(rdata[m]),  32'd0);
      chk($sformatf("rst%0d_ovf", m),    32'(ovf[m]),    32'd0);
      chk($sformatf("rst%0d_udf", m),    32'(udf[m]),    32'd0);
    end
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_all();
    drive(1, 8'h3C, 0, 0, 0); tick();
    drive(0, 8'h00, 0, 0, 0); tick();
    chk("postrst_f_data", 32'(rdata[1]), 32'h3C);
    drive(0, 8'h00, 1, 0, 0); tick();
    chk("postrst_s_data", 32'(rdata[0]), 32'h3C);
    chk("postrst_s_valid", 32'(rvalid[0]), 32'd1);

    // Random traffic against the queue model
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50,
            $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5);
      tick();
    end
    drive(0, 8'h00, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
